// File: rtl/ysyx_22040237_pkg.sv
// rtl/ysyx_22040237_pkg.sv - shared widths, reset PC and fetch-queue entry type for the IFU
package ysyx_22040237_pkg;

    localparam int          XLEN       = 64;
    localparam int          ILEN       = 32;
    localparam logic [63:0] RESET_PC   = 64'h8000_0000;
    localparam int          INST_BYTES = 4;

    // One buffered fetch result: the instruction, its PC and whether memory faulted.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22040237_ifu_fetch_queue_if.sv
// rtl/ysyx_22040237_ifu_fetch_queue_if.sv - instruction-memory request/response bundle
// Request side:  imem_req_valid/imem_req_ready handshake carrying imem_req_addr.
// Response side: imem_rsp_valid with imem_rsp_data/imem_rsp_err, in order, never back-pressured.
// master = fetch unit, slave = instruction memory.
interface ysyx_22040237_ifu_fetch_queue_if #(
    parameter int XLEN = ysyx_22040237_pkg::XLEN,
    parameter int ILEN = ysyx_22040237_pkg::ILEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );
endinterface

// File: rtl/ysyx_22040237_sync_fifo.sv
// rtl/ysyx_22040237_sync_fifo.sv - synchronous FIFO with flush, registered head, no bypass
// Ports: clk, rst (sync active-high), flush (drops all entries), push/push_data,
//        pop/pop_data (head entry), count, full, empty.
module ysyx_22040237_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push & ~flush;
        do_pop   = pop & ~flush & (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush) !(push && full));

endmodule

// File: rtl/ysyx_22040237_ifu_fetch_queue.sv
// rtl/ysyx_22040237_ifu_fetch_queue.sv - decoupled instruction fetch with PC-tagged response queue
// Ports: clk, rst (sync active-high); redirect_valid/redirect_pc restart fetch;
//        imem (master) issues pipelined requests and takes in-order responses;
//        inst_valid/inst_ready/inst/inst_pc/inst_fault present the queue head to decode;
//        fetch_pc is the next request address.
module ysyx_22040237_ifu_fetch_queue
    import ysyx_22040237_pkg::fetch_entry_t;
    import ysyx_22040237_pkg::INST_BYTES;
#(
    parameter int              XLEN     = ysyx_22040237_pkg::XLEN,
    parameter int              ILEN     = ysyx_22040237_pkg::ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_22040237_pkg::RESET_PC)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  redirect_valid,
    input  logic [XLEN-1:0]                       redirect_pc,
    ysyx_22040237_ifu_fetch_queue_if.master       imem,
    output logic                                  inst_valid,
    input  logic                                  inst_ready,
    output logic [ILEN-1:0]                       inst,
    output logic [XLEN-1:0]                       inst_pc,
    output logic                                  inst_fault,
    output logic [XLEN-1:0]                       fetch_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_target;
    logic [CW-1:0]   inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, count;
    logic            can_req, req_fire, rsp_fire, push, pop, fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head_entry;

    always_comb begin
        // A request is only issued if its response is guaranteed a queue slot.
        can_req              = ({1'b0, inflight_q} + {1'b0, count}) < SW'(DEPTH);
        imem.imem_req_valid  = can_req & ~redirect_valid & ~rst;
        imem.imem_req_addr   = fetch_pc_q;
        req_fire             = imem.imem_req_valid & imem.imem_req_ready;
        rsp_fire             = imem.imem_rsp_valid & ~rst;
        // Responses to requests issued before a redirect are counted off by drop_cnt.
        push                 = rsp_fire & ~redirect_valid & (drop_cnt_q == '0);
        inst_valid           = ~fifo_empty & ~redirect_valid & ~rst;
        pop                  = inst_valid & inst_ready;
        redirect_target      = redirect_pc & ~XLEN'(INST_BYTES - 1);

        push_entry.pc        = rsp_pc_q;
        push_entry.inst      = imem.imem_rsp_data;
        push_entry.fault     = imem.imem_rsp_err;

        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d = drop_cnt_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = inflight_q - CW'(rsp_fire);
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
        end else begin
            if (rsp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
            if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(INST_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ysyx_22040237_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;
    assign inst_fault = head_entry.fault;
    assign fetch_pc   = fetch_pc_q;

    a_counters: assert property (@(posedge clk) disable iff (rst)
        (drop_cnt_q <= inflight_q) && (inflight_q <= CW'(DEPTH)));
    a_push_room: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule
